t03_fight_referee: RTL and testbench
====================================

Name: t03_fight_referee

Overview:
- Round/match controller for the two-player fighting game.
- Samples both player FSM state/resting outputs on each frame tick (finished) and resolves hits into health.
- Runs the round countdown, decides KO/time-out/draw, counts round wins, and gates the player FSMs via fsm_enable.
- Sits between the two player FSMs and the display/score logic.

Parameters:
- MAX_HEALTH, 7'd100, health loaded at round start.
- ATTACK_DMG, 7'd10, damage of an unblocked attack.
- CHIP_DMG, 7'd2, damage of an attack landing on an active block.
- FPS, 6'd60, frame ticks per displayed second.
- ROUND_SECS, 7'd99, round length in seconds.
- INTRO_FRAMES, 8'd90, frames held in INTRO.
- KO_FRAMES, 8'd120, frames held in KO.
- ROUNDS_TO_WIN, 2'd2, round wins that end the match.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- finished  input  1  one-cycle frame tick; all state updates happen only on cycles where it is high
- start_n  input  1  start button, active-low level
- p1_state  input  2  player 1 FSM state: 00 idle, 01 attack, 10 block
- p1_resting  input  1  player 1 move inactive
- p2_state  input  2  player 2 FSM state (same encoding as p1_state)
- p2_resting  input  1  player 2 move inactive
- game_state  output  3  000 IDLE, 001 INTRO, 010 FIGHT, 011 KO, 100 OVER
- fsm_enable  output  1  high only in FIGHT; gates the player FSM ticks
- p1_health  output  7  player 1 remaining health
- p2_health  output  7  player 2 remaining health
- timer_secs  output  7  seconds remaining in the round
- p1_wins  output  2  player 1 rounds won
- p2_wins  output  2  player 2 rounds won
- round_result  output  2  00 none, 01 P1 wins round, 10 P2 wins round, 11 draw
- hit_p1  output  1  one-cycle pulse: player 1 took damage this tick
- hit_p2  output  1  one-cycle pulse: player 2 took damage this tick

Behaviour:
- Reset (asynchronous): game_state=IDLE, both health=MAX_HEALTH, timer_secs=ROUND_SECS, wins=0, round_result=00, hit pulses=0, internal frame/hold counters=0, hit_done flags=0, start_prev=1.
- No register changes on cycles where finished=0. hit_p1/hit_p2 are registered and cleared on every clock where no hit is applied, so each is high for exactly one clk cycle.
- Start press: start_n sampled on ticks. A press is start_prev=1 and start_n=0; start_prev then updates on that tick.
- IDLE:
  - Start press → INTRO; clear wins and round_result.
- INTRO:
  - On entry: health=MAX_HEALTH, timer_secs=ROUND_SECS, frame sub-counter=0, round_result=00, hit_done flags cleared.
  - Hold INTRO_FRAMES ticks, then → FIGHT.
- FIGHT:
  - Active attack of Pn: pn_state=01 and pn_resting=0.
  - Active block of Pn: pn_state=10 and pn_resting=0.
  - Per tick: if P1 has an active attack and p1_hit_done=0, then P2 health -= (P2 active block ? CHIP_DMG : ATTACK_DMG), p1_hit_done<=1, and hit_p2 pulses. P2 → P1 is symmetric.
  - Both players' hits are evaluated and applied on the same tick.
  - Subtraction saturates at 0; health never wraps.
  - pn_hit_done clears on any tick where pn_state≠01. A single attack therefore deals at most one hit.
  - Timer: sub-counter counts ticks 0..FPS-1. On wrap, timer_secs decrements, stopping at 0.
  - Round end is evaluated after that tick's damage. Priority: KO, then time-out.
    - KO: one health=0 → other player wins (01/10); both 0 → draw (11).
    - Time-out: timer_secs reaches 0 → higher health wins; equal health → draw.
  - On round end: increment the winner's win count (draws increment nothing), set round_result, → KO.
- KO:
  - fsm_enable=0; health and round_result hold.
  - After KO_FRAMES ticks: if either win count = ROUNDS_TO_WIN → OVER, else → INTRO.
- OVER:
  - Everything holds.
  - Start press → IDLE.
- Presses in INTRO, FIGHT and KO are ignored.
- Illegal game_state code → IDLE on the next tick.
- Reset mid-round returns to IDLE immediately, with no pulse outputs asserted.

Test Plan:
- Reset, start_n low on a tick → INTRO. After 90 ticks → FIGHT with fsm_enable=1, both health=100, timer_secs=99.
- P1 attack active (01, resting=0) for 30 ticks, P2 idle → P2 health 100→90 exactly once, single hit_p2 pulse. Second attack after p1_state returns to 00 → 80.
- P1 attack while P2 in 10 with resting=0 → P2 health -2. Same attack with P2 resting=1 → -10.
- Both attack on the same tick with both health=10 → both 0, round_result=11, no wins incremented, KO, then INTRO after 120 ticks.
- No hits for 99×60 ticks with P1=100, P2=90 → timer_secs reaches 0, round_result=01, p1_wins=1.
- P1 wins two rounds → OVER held with p1_wins=2. Start press → IDLE. Assert rst mid-FIGHT → all reset values asynchronously.

Source files
------------

// File: rtl/t03_fight_referee.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : t03_fight_referee                                             |
// | Purpose  : Round/match controller: resolves hits into health, runs the   |
// |            round clock, decides KO/time-out/draw and gates player FSMs.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module t03_fight_referee #(
  parameter logic [6:0] MAX_HEALTH    = 7'd100,
  parameter logic [6:0] ATTACK_DMG    = 7'd10,
  parameter logic [6:0] CHIP_DMG      = 7'd2,
  parameter logic [5:0] FPS           = 6'd60,
  parameter logic [6:0] ROUND_SECS    = 7'd99,
  parameter logic [7:0] INTRO_FRAMES  = 8'd90,
  parameter logic [7:0] KO_FRAMES     = 8'd120,
  parameter logic [1:0] ROUNDS_TO_WIN = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       finished,
  input  logic       start_n,
  input  logic [1:0] p1_state,
  input  logic       p1_resting,
  input  logic [1:0] p2_state,
  input  logic       p2_resting,
  output logic [2:0] game_state,
  output logic       fsm_enable,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic [6:0] timer_secs,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_result,
  output logic       hit_p1,
  output logic       hit_p2
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INTRO = 3'd1;
  localparam logic [2:0] ST_FIGHT = 3'd2;
  localparam logic [2:0] ST_KO    = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [6:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [6:0] timer_q, timer_d;
  logic [5:0] frame_q, frame_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
  logic [1:0] result_q, result_d;
  logic       hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
  logic       p1_hit_done_q, p1_hit_done_d, p2_hit_done_q, p2_hit_done_d;
  logic       start_prev_q, start_prev_d;

  logic       w_press;
  logic       w_p1_atk, w_p1_blk, w_p2_atk, w_p2_blk;
  logic       w_p1_strike, w_p2_strike;
  logic [6:0] w_dmg_to_p1, w_dmg_to_p2;
  logic [6:0] w_p1_health_nx, w_p2_health_nx;
  logic       w_frame_wrap;
  logic [5:0] w_frame_nx;
  logic [6:0] w_timer_nx;
  logic [1:0] w_round_result;
  logic       w_round_end;
  logic       w_intro_done, w_ko_done, w_match_won, w_load_round;

  assign w_press     = start_prev_q & ~start_n;
  assign w_p1_atk    = (p1_state == 2'b01) & ~p1_resting;
  assign w_p1_blk    = (p1_state == 2'b10) & ~p1_resting;
  assign w_p2_atk    = (p2_state == 2'b01) & ~p2_resting;
  assign w_p2_blk    = (p2_state == 2'b10) & ~p2_resting;
  assign w_p1_strike = w_p1_atk & ~p1_hit_done_q;
  assign w_p2_strike = w_p2_atk & ~p2_hit_done_q;
  assign w_dmg_to_p1 = w_p1_blk ? CHIP_DMG : ATTACK_DMG;
  assign w_dmg_to_p2 = w_p2_blk ? CHIP_DMG : ATTACK_DMG;

  // Health saturates at zero rather than wrapping
  assign w_p1_health_nx = !w_p2_strike ? p1_health_q :
                          (p1_health_q >= w_dmg_to_p1) ? p1_health_q - w_dmg_to_p1 : 7'd0;
  assign w_p2_health_nx = !w_p1_strike ? p2_health_q :
                          (p2_health_q >= w_dmg_to_p2) ? p2_health_q - w_dmg_to_p2 : 7'd0;

  assign w_frame_wrap = (frame_q == FPS - 6'd1);
  assign w_frame_nx   = w_frame_wrap ? 6'd0 : frame_q + 6'd1;
  assign w_timer_nx   = (w_frame_wrap && timer_q != 7'd0) ? timer_q - 7'd1 : timer_q;

  // KO outranks time-out; evaluated on post-damage health and post-tick timer
  always_comb begin
    w_round_result = 2'b00;
    if (w_p1_health_nx == 7'd0 && w_p2_health_nx == 7'd0)
      w_round_result = 2'b11;
    else if (w_p2_health_nx == 7'd0)
      w_round_result = 2'b01;
    else if (w_p1_health_nx == 7'd0)
      w_round_result = 2'b10;
    else if (w_timer_nx == 7'd0) begin
      if (w_p1_health_nx > w_p2_health_nx)
        w_round_result = 2'b01;
      else if (w_p2_health_nx > w_p1_health_nx)
        w_round_result = 2'b10;
      else
        w_round_result = 2'b11;
    end
  end

  assign w_round_end  = (w_round_result != 2'b00);
  assign w_intro_done = (hold_q == INTRO_FRAMES - 8'd1);
  assign w_ko_done    = (hold_q == KO_FRAMES - 8'd1);
  assign w_match_won  = (p1_wins_q == ROUNDS_TO_WIN) || (p2_wins_q == ROUNDS_TO_WIN);
  assign w_load_round = finished &&
                        ((state_q == ST_IDLE && w_press) ||
                         (state_q == ST_KO && w_ko_done && !w_match_won));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (finished) begin
      case (state_q)
        ST_IDLE:  if (w_press) state_d = ST_INTRO;
        ST_INTRO: if (w_intro_done) state_d = ST_FIGHT;
        ST_FIGHT: if (w_round_end) state_d = ST_KO;
        ST_KO:    if (w_ko_done) state_d = w_match_won ? ST_OVER : ST_INTRO;
        ST_OVER:  if (w_press) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    game_state = state_q;
    fsm_enable = (state_q == ST_FIGHT);
  end

  always_comb begin
    p1_health_d   = p1_health_q;
    p2_health_d   = p2_health_q;
    timer_d       = timer_q;
    frame_d       = frame_q;
    hold_d        = hold_q;
    p1_wins_d     = p1_wins_q;
    p2_wins_d     = p2_wins_q;
    result_d      = result_q;
    hit_p1_d      = 1'b0;
    hit_p2_d      = 1'b0;
    p1_hit_done_d = p1_hit_done_q;
    p2_hit_done_d = p2_hit_done_q;
    start_prev_d  = start_prev_q;
    if (finished) begin
      start_prev_d = start_n;
      case (state_q)
        ST_IDLE: begin
          if (w_press) begin
            p1_wins_d = 2'd0;
            p2_wins_d = 2'd0;
          end
        end
        ST_INTRO: hold_d = w_intro_done ? 8'd0 : hold_q + 8'd1;
        ST_FIGHT: begin
          p1_health_d   = w_p1_health_nx;
          p2_health_d   = w_p2_health_nx;
          hit_p1_d      = w_p2_strike;
          hit_p2_d      = w_p1_strike;
          // A hit is latched until the attacker leaves the attack state
          p1_hit_done_d = (p1_state == 2'b01) & (p1_hit_done_q | w_p1_strike);
          p2_hit_done_d = (p2_state == 2'b01) & (p2_hit_done_q | w_p2_strike);
          frame_d       = w_frame_nx;
          timer_d       = w_timer_nx;
          if (w_round_end) begin
            result_d = w_round_result;
            hold_d   = 8'd0;
            if (w_round_result == 2'b01) p1_wins_d = p1_wins_q + 2'd1;
            if (w_round_result == 2'b10) p2_wins_d = p2_wins_q + 2'd1;
          end
        end
        ST_KO:   hold_d = w_ko_done ? 8'd0 : hold_q + 8'd1;
        default: ;
      endcase
      if (w_load_round) begin
        p1_health_d   = MAX_HEALTH;
        p2_health_d   = MAX_HEALTH;
        timer_d       = ROUND_SECS;
        frame_d       = 6'd0;
        hold_d        = 8'd0;
        result_d      = 2'b00;
        p1_hit_done_d = 1'b0;
        p2_hit_done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_health_q   <= MAX_HEALTH;
      p2_health_q   <= MAX_HEALTH;
      timer_q       <= ROUND_SECS;
      frame_q       <= 6'd0;
      hold_q        <= 8'd0;
      p1_wins_q     <= 2'd0;
      p2_wins_q     <= 2'd0;
      result_q      <= 2'b00;
      hit_p1_q      <= 1'b0;
      hit_p2_q      <= 1'b0;
      p1_hit_done_q <= 1'b0;
      p2_hit_done_q <= 1'b0;
      start_prev_q  <= 1'b1;
    end else begin
      p1_health_q   <= p1_health_d;
      p2_health_q   <= p2_health_d;
      timer_q       <= timer_d;
      frame_q       <= frame_d;
      hold_q        <= hold_d;
      p1_wins_q     <= p1_wins_d;
      p2_wins_q     <= p2_wins_d;
      result_q      <= result_d;
      hit_p1_q      <= hit_p1_d;
      hit_p2_q      <= hit_p2_d;
      p1_hit_done_q <= p1_hit_done_d;
      p2_hit_done_q <= p2_hit_done_d;
      start_prev_q  <= start_prev_d;
    end
  end

  assign p1_health    = p1_health_q;
  assign p2_health    = p2_health_q;
  assign timer_secs   = timer_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;
  assign round_result = result_q;
  assign hit_p1       = hit_p1_q;
  assign hit_p2       = hit_p2_q;

endmodule
`default_nettype wire

// File: tb/tb_t03_fight_referee.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_t03_fight_referee                                          |
// | Purpose  : Directed self-checking bench for the fight referee.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_t03_fight_referee;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       finished = 1'b0;
  logic       start_n = 1'b1;
  logic [1:0] p1_state = 2'b00;
  logic       p1_resting = 1'b1;
  logic [1:0] p2_state = 2'b00;
  logic       p2_resting = 1'b1;
  logic [2:0] game_state;
  logic       fsm_enable;
  logic [6:0] p1_health, p2_health, timer_secs;
  logic [1:0] p1_wins, p2_wins, round_result;
  logic       hit_p1, hit_p2;

  int   ncmp = 0;
  int   nerr = 0;
  int   h1cnt = 0;
  int   h2cnt = 0;
  logic last_h1 = 1'b0;
  logic last_h2 = 1'b0;

  t03_fight_referee dut (
    .clk(clk), .rst(rst), .finished(finished), .start_n(start_n),
    .p1_state(p1_state), .p1_resting(p1_resting),
    .p2_state(p2_state), .p2_resting(p2_resting),
    .game_state(game_state), .fsm_enable(fsm_enable),
    .p1_health(p1_health), .p2_health(p2_health), .timer_secs(timer_secs),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .round_result(round_result),
    .hit_p1(hit_p1), .hit_p2(hit_p2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick followed by one idle clock; pulse cycles are counted on both.
  task automatic tick();
    finished = 1'b1;
    @(posedge clk); #1;
    finished = 1'b0;
    last_h1 = hit_p1;
    last_h2 = hit_p2;
    if (hit_p1) h1cnt++;
    if (hit_p2) h2cnt++;
    @(posedge clk); #1;
    if (hit_p1) h1cnt++;
    if (hit_p2) h2cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic p1_set(input logic [1:0] s, input logic r);
    p1_state = s; p1_resting = r;
  endtask

  task automatic p2_set(input logic [1:0] s, input logic r);
    p2_state = s; p2_resting = r;
  endtask

  task automatic p1_strike();
    p1_set(2'b01, 1'b0); tick(); p1_set(2'b00, 1'b1); tick();
  endtask

  task automatic p2_strike();
    p2_set(2'b01, 1'b0); tick(); p2_set(2'b00, 1'b1); tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", game_state, 0);
    chk("rst_enable", fsm_enable, 0);
    chk("rst_p1_health", p1_health, 100);
    chk("rst_p2_health", p2_health, 100);
    chk("rst_timer", timer_secs, 99);
    chk("rst_p1_wins", p1_wins, 0);
    chk("rst_p2_wins", p2_wins, 0);
    chk("rst_result", round_result, 0);
    chk("rst_hit_p1", hit_p1, 0);
    chk("rst_hit_p2", hit_p2, 0);
    rst = 1'b0;

    // Round 1: hit mechanics, then a double KO draw
    start_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_tick", game_state, 0);
    tick();
    chk("press_intro", game_state, 1);
    for (int i = 0; i < 89; i++) begin
      start_n = (i == 10) ? 1'b0 : 1'b1;
      tick();
    end
    start_n = 1'b1;
    chk("intro_hold", game_state, 1);
    tick();
    chk("fight_state", game_state, 2);
    chk("fight_enable", fsm_enable, 1);
    chk("fight_p1_health", p1_health, 100);
    chk("fight_p2_health", p2_health, 100);
    chk("fight_timer", timer_secs, 99);

    p1_set(2'b01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("gated_p2_health", p2_health, 100);
    h2cnt = 0;
    ticks(30);
    chk("long_attack_p2", p2_health, 90);
    chk("long_attack_pulses", h2cnt, 1);
    chk("long_attack_p1", p1_health, 100);
    p1_set(2'b00, 1'b1); tick();
    p1_set(2'b01, 1'b0); ticks(2);
    chk("second_attack", p2_health, 80);
    p1_set(2'b00, 1'b1); tick();
    p2_set(2'b10, 1'b0); p1_set(2'b01, 1'b0); tick();
    chk("chip_damage", p2_health, 78);
    chk("chip_pulse", last_h2, 1);
    p1_set(2'b00, 1'b1); tick();
    p2_set(2'b10, 1'b1); p1_set(2'b01, 1'b0); tick();
    chk("resting_block", p2_health, 68);
    p1_set(2'b00, 1'b1); tick();
    p2_set(2'b00, 1'b1);
    repeat (5) p1_strike();
    p2_set(2'b10, 1'b0);
    repeat (4) p1_strike();
    p2_set(2'b00, 1'b1);
    chk("p2_at_10", p2_health, 10);
    h1cnt = 0;
    repeat (9) p2_strike();
    chk("p1_at_10", p1_health, 10);
    chk("p1_pulses", h1cnt, 9);
    p1_set(2'b01, 1'b0); p2_set(2'b01, 1'b0); tick();
    chk("dko_pulse_p1", last_h1, 1);
    chk("dko_pulse_p2", last_h2, 1);
    chk("dko_p1_health", p1_health, 0);
    chk("dko_p2_health", p2_health, 0);
    chk("dko_state", game_state, 3);
    chk("dko_result", round_result, 3);
    chk("dko_p1_wins", p1_wins, 0);
    chk("dko_p2_wins", p2_wins, 0);
    chk("dko_enable", fsm_enable, 0);
    chk("dko_timer", timer_secs, 98);
    p1_set(2'b00, 1'b1); p2_set(2'b00, 1'b1);
    ticks(119);
    chk("ko_hold_state", game_state, 3);
    chk("ko_hold_result", round_result, 3);
    chk("ko_hold_health", p1_health, 0);
    tick();
    chk("ko_to_intro", game_state, 1);
    chk("intro_p1_health", p1_health, 100);
    chk("intro_p2_health", p2_health, 100);
    chk("intro_timer", timer_secs, 99);
    chk("intro_result", round_result, 0);

    // Round 2: time-out won on health
    ticks(90);
    chk("r2_fight", game_state, 2);
    p1_strike();
    chk("r2_p2_health", p2_health, 90);
    for (int i = 0; i < 5937; i++) begin
      start_n = (i == 100) ? 1'b0 : 1'b1;
      tick();
    end
    start_n = 1'b1;
    chk("r2_timer_1", timer_secs, 1);
    chk("r2_still_fight", game_state, 2);
    tick();
    chk("r2_timeout_state", game_state, 3);
    chk("r2_timer_0", timer_secs, 0);
    chk("r2_result", round_result, 1);
    chk("r2_p1_wins", p1_wins, 1);
    chk("r2_p2_wins", p2_wins, 0);
    ticks(120);
    chk("r2_to_intro", game_state, 1);
    chk("r2_wins_hold", p1_wins, 1);

    // Round 3: P1 KO with saturating damage ends the match
    ticks(90);
    chk("r3_fight", game_state, 2);
    p2_set(2'b10, 1'b0);
    repeat (3) p1_strike();
    p2_set(2'b00, 1'b1);
    chk("r3_chips", p2_health, 94);
    repeat (9) p1_strike();
    chk("r3_p2_at_4", p2_health, 4);
    chk("r3_not_ko", game_state, 2);
    p1_set(2'b01, 1'b0); tick();
    p1_set(2'b00, 1'b1);
    chk("r3_saturate", p2_health, 0);
    chk("r3_ko_state", game_state, 3);
    chk("r3_result", round_result, 1);
    chk("r3_p1_wins", p1_wins, 2);
    ticks(119);
    chk("r3_ko_hold", game_state, 3);
    tick();
    chk("over_state", game_state, 4);
    chk("over_enable", fsm_enable, 0);
    ticks(5);
    chk("over_hold_state", game_state, 4);
    chk("over_hold_p2", p2_health, 0);
    chk("over_hold_result", round_result, 1);
    chk("over_hold_wins", p1_wins, 2);
    start_n = 1'b0; tick(); start_n = 1'b1;
    chk("over_to_idle", game_state, 0);

    // New match, then asynchronous reset mid-fight with a hit pulse high
    tick();
    start_n = 1'b0; tick(); start_n = 1'b1;
    chk("m2_intro", game_state, 1);
    chk("m2_wins_cleared", p1_wins, 0);
    ticks(90);
    chk("m2_fight", game_state, 2);
    p1_set(2'b01, 1'b0);
    finished = 1'b1;
    @(posedge clk); #1;
    finished = 1'b0;
    chk("m2_hit_pulse", hit_p2, 1);
    chk("m2_p2_health", p2_health, 90);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", game_state, 0);
    chk("arst_p2_health", p2_health, 100);
    chk("arst_hit_p2", hit_p2, 0);
    chk("arst_timer", timer_secs, 99);
    chk("arst_enable", fsm_enable, 0);
    #2 rst = 1'b0;
    p1_set(2'b00, 1'b1);
    tick();
    chk("post_rst_idle", game_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
